// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, optional parity, 1 or 2 stop bits.
// Each word is delivered as a one-cycle rx_valid pulse; data and error flags hold until the next.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter string       PARITY_TYPE = "none",
  parameter int unsigned STOP_BITS   = 1,
  parameter string       FIRST_BIT   = "lsb",
  parameter int unsigned BAUDRATE    = 115200,
  parameter int unsigned CLK_FREQ    = 75_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int unsigned FULLBAUD  = CLK_FREQ / BAUDRATE;
  localparam int unsigned HALFBAUD  = FULLBAUD / 2;
  localparam int unsigned CNT_W     = (FULLBAUD > 2) ? $clog2(FULLBAUD) : 1;
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
  localparam bit          PAR_EN    = (PARITY_TYPE != "none");
  localparam bit          PAR_ODD   = (PARITY_TYPE == "odd");
  localparam bit          MSB_FIRST = (FIRST_BIT == "msb");

  localparam logic [CNT_W-1:0] FULL_END  = CNT_W'(FULLBAUD - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALFBAUD - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 fall;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shreg_shift;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d, ferr_next;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 out_perr_q, out_perr_d;
  logic                 out_ferr_q, out_ferr_d;
  logic                 full_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A falling edge needs a high previous sample, so a held-low line never re-triggers.
  assign fall      = rx_prev_q & ~rx_s_q;
  assign full_tick = (cnt_q == FULL_END);
  assign ferr_next = ferr_q | ~rx_s_q;
  assign shreg_shift = MSB_FIRST ? {shreg_q[DATA_BITS-2:0], rx_s_q}
                                 : {rx_s_q, shreg_q[DATA_BITS-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    out_perr_d = out_perr_q;
    out_ferr_d = out_ferr_q;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = StData;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (full_tick) begin
          cnt_d   = '0;
          shreg_d = shreg_shift;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = PAR_EN ? StParity : StStop;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StParity: begin
        if (full_tick) begin
          cnt_d   = '0;
          perr_d  = PAR_ODD ? ((^shreg_q) == rx_s_q) : ((^shreg_q) != rx_s_q);
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (full_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_next;
          if (bit_q == STOP_LAST) begin
            // Outputs are registered here so the pulse lands the cycle after the last sample.
            bit_d      = '0;
            valid_d    = 1'b1;
            data_d     = shreg_q;
            out_perr_d = perr_q;
            out_ferr_d = ferr_next;
            state_d    = StIdle;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      out_perr_q <= out_perr_d;
      out_ferr_q <= out_ferr_d;
    end
  end

  assign rx_valid      = valid_q;
  assign rx_data       = data_q;
  assign rx_parity_err = out_perr_q;
  assign rx_frame_err  = out_ferr_q;

endmodule
